// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache in front of Fetch.
// Addresses are instruction indices; a hit answers combinationally in the same cycle,
// a miss runs a refill FSM (one line request, then a BEATS-long data burst).
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
//
// Handshakes: out_mem_req is held with a stable out_mem_addr until a cycle in which
// in_mem_ack is sampled high; from the following cycle every cycle with in_mem_valid
// high carries exactly one beat (lowest instruction in the low bits); in_mem_valid is
// ignored while the request is still outstanding. out_ready qualifies
// out_instruction_bits in the same cycle and is never asserted outside IDLE.
module instruction_cache #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int BUS_WIDTH         = 64,
  parameter int LINES             = 64,
  parameter int WORDS_PER_LINE    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_req,
  input  logic [ADDRESS_WIDTH-1:0]     in_pc,
  input  logic                         in_flush,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits,
  output logic                         out_ready,
  output logic                         out_mem_req,
  output logic [ADDRESS_WIDTH-1:0]     out_mem_addr,
  input  logic                         in_mem_ack,
  input  logic                         in_mem_valid,
  input  logic [BUS_WIDTH-1:0]         in_mem_data,
`ifdef ICACHE_STATS_EN
  output logic [31:0]                  out_hit_count,
  output logic [31:0]                  out_miss_count,
`endif
  output logic [1:0]                   out_state
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDRESS_WIDTH - OFF_W - IDX_W;
  localparam int BEATS = WORDS_PER_LINE * INSTRUCTION_WIDTH / BUS_WIDTH;
  localparam int WPB   = BUS_WIDTH / INSTRUCTION_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_REFILL = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       mem_req_q, mem_req_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic                       poison_q, poison_d;

  logic                       valid_q [LINES];
  logic [TAG_W-1:0]           tag_q   [LINES];
  logic [INSTRUCTION_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0]           pc_off;
  logic [IDX_W-1:0]           pc_idx;
  logic [TAG_W-1:0]           pc_tag;
  logic [IDX_W-1:0]           fill_idx;
  logic [TAG_W-1:0]           fill_tag;
  logic                       hit;
  logic                       miss_start;
  logic                       beat_we;
  logic                       line_done;
  logic                       set_valid;

  assign pc_off   = in_pc[OFF_W-1:0];
  assign pc_idx   = in_pc[OFF_W +: IDX_W];
  assign pc_tag   = in_pc[ADDRESS_WIDTH-1 -: TAG_W];
  assign fill_idx = addr_q[OFF_W +: IDX_W];
  assign fill_tag = addr_q[ADDRESS_WIDTH-1 -: TAG_W];

  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign out_ready = (state_q == S_IDLE) && in_req && !in_flush && hit;
  assign out_instruction_bits = out_ready ? data_q[pc_idx][pc_off] : '0;
  assign out_mem_req  = mem_req_q;
  assign out_mem_addr = addr_q;
  assign out_state    = state_q;

  // A flush arriving in the same cycle as the last beat must still leave the line invalid.
  assign set_valid = line_done && !poison_q && !in_flush;

  // Next-state logic for the refill FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    addr_d     = addr_q;
    poison_d   = poison_q;
    miss_start = 1'b0;
    beat_we    = 1'b0;
    line_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_flush && in_req && !hit) begin
          addr_d     = {in_pc[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          mem_req_d  = 1'b1;
          poison_d   = 1'b0;
          miss_start = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (in_flush) poison_d = 1'b1;
        if (in_mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (in_flush) poison_d = 1'b1;
        if (in_mem_valid) begin
          beat_we = 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            line_done = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and refill bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      poison_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      poison_q  <= poison_d;
    end
  end

  // Valid bits: flush clears everything; the victim line is dropped as soon as its refill starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
    end else if (in_flush) begin
      for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
    end else if (miss_start) begin
      valid_q[pc_idx] <= 1'b0;
    end else if (set_valid) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag array, written once per completed refill.
  always_ff @(posedge clk) begin
    if (line_done) tag_q[fill_idx] <= fill_tag;
  end

  // Data array: each beat fills WPB consecutive words starting at cnt*WPB.
  always_ff @(posedge clk) begin
    if (beat_we) begin
      for (int j = 0; j < WPB; j++) begin
        data_q[fill_idx][OFF_W'(32'(cnt_q) * WPB + j)] <= in_mem_data[j*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign out_hit_count  = hit_cnt_q;
  assign out_miss_count = miss_cnt_q;

  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (out_ready && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif

endmodule
